// File: rtl/i2c_host_pkg.sv
// Shared types, default bus timing and a small helper for the I2C host byte engine.
package i2c_host_pkg;

  typedef enum logic [3:0] {
    IDLE_FREE, IDLE_HELD, RS_LOW, RS_SETUP, START_HOLD, BIT_LOW,
    BIT_HIGH, ACK_LOW, ACK_HIGH, STOP_LOW, STOP_SETUP, STOP_HOLD
  } state_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       nack;
    logic [7:0] data;
  } cmd_t;

  localparam int unsigned DEF_T_CLOCK_LOW   = 4;
  localparam int unsigned DEF_T_CLOCK_HIGH  = 4;
  localparam int unsigned DEF_T_SETUP_START = 4;
  localparam int unsigned DEF_T_HOLD_START  = 4;
  localparam int unsigned DEF_T_SETUP_STOP  = 4;
  localparam int unsigned DEF_T_HOLD_STOP   = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_host_phase_cnt.sv
// Loadable phase down-counter: load_val cycles per phase, frozen while stall is high.
// done is combinational and marks the last cycle of the phase.
module i2c_host_phase_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         stall,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (!stall && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0) && !stall;

endmodule

// File: rtl/i2c_host_byte_ctrl.sv
// I2C host byte engine: START/repeated START, 8 bits MSB-first, ACK bit, optional STOP; one command per byte.
// Define I2C_HOST_CLK_STRETCH_EN to let a target stretch SCL high phases; otherwise scl_i is ignored.
module i2c_host_byte_ctrl
  import i2c_host_pkg::*;
#(
  parameter int unsigned T_CLOCK_LOW   = DEF_T_CLOCK_LOW,
  parameter int unsigned T_CLOCK_HIGH  = DEF_T_CLOCK_HIGH,
  parameter int unsigned T_SETUP_START = DEF_T_SETUP_START,
  parameter int unsigned T_HOLD_START  = DEF_T_HOLD_START,
  parameter int unsigned T_SETUP_STOP  = DEF_T_SETUP_STOP,
  parameter int unsigned T_HOLD_STOP   = DEF_T_HOLD_STOP
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_start_i,
  input  logic       cmd_stop_i,
  input  logic       cmd_read_i,
  input  logic       cmd_nack_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_nak_o,
  output logic       busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o
);

  localparam int unsigned T_MAX = max2(max2(max2(T_CLOCK_LOW, T_CLOCK_HIGH),
                                            max2(T_SETUP_START, T_HOLD_START)),
                                       max2(T_SETUP_STOP, T_HOLD_STOP));
  localparam int unsigned CW = $clog2(T_MAX + 1);

  if (T_CLOCK_LOW == 0 || T_CLOCK_HIGH == 0 || T_SETUP_START == 0 ||
      T_HOLD_START == 0 || T_SETUP_STOP == 0 || T_HOLD_STOP == 0) begin : g_param_check
    $error("i2c_host_byte_ctrl: every timing parameter must be at least 1");
  end

  state_t        state;
  cmd_t          cmd;
  logic          accept;
  logic          cnt_load, cnt_done, stall;
  logic [CW-1:0] nxt_len;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          stop_q, read_q, nack_q;

  assign cmd    = {cmd_start_i, cmd_stop_i, cmd_read_i, cmd_nack_i, cmd_data_i};
  assign accept = cmd_valid_i && cmd_ready_o;

`ifdef I2C_HOST_CLK_STRETCH_EN
  assign stall = !scl_i && (state inside {BIT_HIGH, ACK_HIGH, RS_SETUP, STOP_SETUP});
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stall      = 1'b0;
`endif

  // Length of the phase entered when the current one ends (or a command is taken).
  always_comb begin
    nxt_len = CW'(T_CLOCK_LOW);
    case (state)
      IDLE_FREE:           nxt_len = CW'(T_HOLD_START);
      RS_LOW:              nxt_len = CW'(T_SETUP_START);
      RS_SETUP:            nxt_len = CW'(T_HOLD_START);
      BIT_LOW, ACK_LOW:    nxt_len = CW'(T_CLOCK_HIGH);
      STOP_LOW:            nxt_len = CW'(T_SETUP_STOP);
      STOP_SETUP:          nxt_len = CW'(T_HOLD_STOP);
      default:             nxt_len = CW'(T_CLOCK_LOW);
    endcase
  end

  assign cnt_load = (state == IDLE_FREE || state == IDLE_HELD) ? accept : cnt_done;

  i2c_host_phase_cnt #(.W(CW)) u_phase_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (cnt_load),
    .load_val (nxt_len),
    .stall    (stall),
    .done     (cnt_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE_FREE;
      scl_o       <= 1'b1;
      sda_o       <= 1'b1;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 8'h00;
      rsp_nak_o   <= 1'b0;
      busy_o      <= 1'b0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      stop_q      <= 1'b0;
      read_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE_FREE, IDLE_HELD: if (accept) begin
          cmd_ready_o <= 1'b0;
          stop_q      <= cmd.stop;
          read_q      <= cmd.read;
          nack_q      <= cmd.nack;
          // Reads shift out all ones so the same path releases SDA for every bit.
          shreg       <= cmd.read ? 8'hFF : cmd.data;
          bit_idx     <= 3'd7;
          if (state == IDLE_FREE) begin
            sda_o <= 1'b0;
            state <= START_HOLD;
          end else if (cmd.start) begin
            state <= RS_LOW;
          end else begin
            sda_o <= cmd.read | cmd.data[7];
            state <= BIT_LOW;
          end
        end
        RS_LOW: if (cnt_done) begin
          scl_o <= 1'b1;
          state <= RS_SETUP;
        end
        RS_SETUP: if (cnt_done) begin
          sda_o <= 1'b0;
          state <= START_HOLD;
        end
        START_HOLD: if (cnt_done) begin
          scl_o  <= 1'b0;
          sda_o  <= shreg[7];
          busy_o <= 1'b1;
          state  <= BIT_LOW;
        end
        BIT_LOW: if (cnt_done) begin
          scl_o <= 1'b1;
          state <= BIT_HIGH;
        end
        BIT_HIGH: if (cnt_done) begin
          scl_o <= 1'b0;
          shreg <= {shreg[6:0], sda_i};
          if (bit_idx == 3'd0) begin
            sda_o <= !read_q | nack_q;
            state <= ACK_LOW;
          end else begin
            bit_idx <= bit_idx - 3'd1;
            sda_o   <= shreg[6];
            state   <= BIT_LOW;
          end
        end
        ACK_LOW: if (cnt_done) begin
          scl_o <= 1'b1;
          state <= ACK_HIGH;
        end
        ACK_HIGH: if (cnt_done) begin
          scl_o       <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= shreg;
          rsp_nak_o   <= sda_i;
          if (stop_q) begin
            sda_o <= 1'b0;
            state <= STOP_LOW;
          end else begin
            sda_o       <= 1'b1;
            cmd_ready_o <= 1'b1;
            state       <= IDLE_HELD;
          end
        end
        STOP_LOW: if (cnt_done) begin
          scl_o <= 1'b1;
          state <= STOP_SETUP;
        end
        STOP_SETUP: if (cnt_done) begin
          sda_o <= 1'b1;
          state <= STOP_HOLD;
        end
        STOP_HOLD: if (cnt_done) begin
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE_FREE;
        end
        default: state <= IDLE_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_host_byte_ctrl.sv
// Bench for i2c_host_byte_ctrl: bus-level target model plus byte-transaction reference checks.
module tb_i2c_host_byte_ctrl;

  localparam int TL = 4, TH = 4, TSS = 4, THS = 4, TSP = 4, THP = 4;
`ifdef I2C_HOST_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 20;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       clk_i = 1'b0, rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0, cmd_start_i = 1'b0, cmd_stop_i = 1'b0;
  logic       cmd_read_i = 1'b0, cmd_nack_i = 1'b0;
  logic [7:0] cmd_data_i = 8'h00;
  logic       cmd_ready_o, rsp_valid_o, rsp_nak_o, busy_o, scl_o, sda_o;
  logic [7:0] rsp_data_o;
  logic       tgt_sda = 1'b1, tgt_scl = 1'b1;
  wire        scl_bus = scl_o & tgt_scl;
  wire        sda_bus = sda_o & tgt_sda;

  i2c_host_byte_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_start_i(cmd_start_i), .cmd_stop_i(cmd_stop_i), .cmd_read_i(cmd_read_i),
    .cmd_nack_i(cmd_nack_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_nak_o(rsp_nak_o),
    .busy_o(busy_o), .scl_i(scl_bus), .sda_i(sda_bus), .scl_o(scl_o), .sda_o(sda_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct {
    bit         start, stop, read, nack, ack, stretch;
    logic [7:0] wdata, rdata;
  } tx_t;

  tx_t plan[$];
  tx_t tq[$];
  bit  held = 1'b0;
  bit  stretch_arm = 1'b0;

  // Target and bus monitor: byte position follows host SCL falls, START restarts it.
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         idx = -1, st_cnt = 0;
  bit         rd_ok = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_ack = 1'b1;
  int         start_cnt = 0, stop_cnt = 0, start_cyc = 0, stop_cyc = 0;
  int         rise_cyc = 0, start_gap = 0, stop_gap = 0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      tq.delete();
      idx = -1; rd_ok = 1'b0; tgt_sda = 1'b1; tgt_scl = 1'b1;
      stretch_arm = 1'b0; p_scl = 1'b1; p_sda = 1'b1;
    end else begin
      if (p_scl && scl_o && p_sda && !sda_bus) begin
        start_cnt++; start_cyc = cyc; start_gap = cyc - rise_cyc; idx = -1; rd_ok = 1'b1;
      end
      if (p_scl && scl_o && !p_sda && sda_bus) begin
        stop_cnt++; stop_cyc = cyc; stop_gap = cyc - rise_cyc;
      end
      if (!p_scl && scl_o) begin
        rise_cyc = cyc;
        if (idx >= 0 && idx <= 7) mon_byte = {mon_byte[6:0], sda_bus};
        else if (idx == 8) mon_ack = sda_bus;
      end
      if (p_scl && !scl_o) begin
        if (idx == 8) begin
          if (tq.size() > 0) begin
            rd_ok = tq[0].read && !tq[0].nack;
            void'(tq.pop_front());
          end
          idx = 0;
        end else begin
          idx++;
        end
        if (idx == 3 && stretch_arm) begin
          tgt_scl = 1'b0; st_cnt = 0; stretch_arm = 1'b0;
        end
      end
      if (!tgt_scl && scl_o) begin
        st_cnt++;
        if (st_cnt == 20) tgt_scl = 1'b1;
      end
      tgt_sda = 1'b1;
      if (tq.size() > 0) begin
        if (idx >= 0 && idx <= 7 && tq[0].read && rd_ok) tgt_sda = tq[0].rdata[7-idx];
        else if (idx == 8 && !tq[0].read && tq[0].ack) tgt_sda = 1'b0;
      end
      p_scl = scl_o;
      p_sda = sda_bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_plan();
    foreach (plan[k]) tq.push_back(plan[k]);
    for (int i = 0; i < plan.size(); i++) begin
      tx_t        t = plan[i];
      int         a, r, f, n, lat, sc0, pc0;
      logic [7:0] exp_data;
      logic       exp_nak;
      exp_data = t.read ? t.rdata : t.wdata;
      exp_nak  = t.read ? t.nack : !t.ack;
      lat = 1 + 9 * (TL + TH) + (!held ? THS : (t.start ? TL + TSS + THS : 0))
            + (t.stretch ? STRETCH_EXTRA : 0);
      n = 0;
      @(negedge clk_i);
      while (!cmd_ready_o && n < 2000) begin @(negedge clk_i); n++; end
      check("ready_wait", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b1; cmd_start_i = t.start; cmd_stop_i = t.stop;
      cmd_read_i = t.read; cmd_nack_i = t.nack; cmd_data_i = t.wdata;
      stretch_arm = t.stretch;
      a = cyc; sc0 = start_cnt; pc0 = stop_cnt;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      check("ready_drop", 32'(cmd_ready_o), 32'd0);
      n = 0;
      while (!rsp_valid_o && n < 3000) begin @(negedge clk_i); n++; end
      r = cyc;
      check("rsp_seen", 32'(rsp_valid_o), 32'd1);
      check("rsp_latency", 32'(r - a), 32'(lat));
      check("rsp_data", 32'(rsp_data_o), 32'(exp_data));
      check("rsp_nak", 32'(rsp_nak_o), 32'(exp_nak));
      check("busy_at_rsp", 32'(busy_o), 32'd1);
      check("bus_byte", 32'(mon_byte), 32'(exp_data));
      check("bus_ack", 32'(mon_ack), 32'(exp_nak));
      check("no_stop_in_byte", 32'(stop_cnt), 32'(pc0));
      if (!held || t.start) begin
        check("start_seen", 32'(start_cnt), 32'(sc0 + 1));
        check("start_time", 32'(start_cyc - a), 32'(held ? TL + TSS + 1 : 1));
        if (held) check("rs_setup", 32'(start_gap), 32'(TSS));
      end else begin
        check("no_start", 32'(start_cnt), 32'(sc0));
      end
      check("ready_at_rsp", 32'(cmd_ready_o), 32'(!t.stop));
      if (t.stop) begin
        n = 0;
        while (busy_o && n < 1000) begin @(negedge clk_i); n++; end
        f = cyc;
        check("stop_seen", 32'(stop_cnt), 32'(pc0 + 1));
        check("stop_setup", 32'(stop_gap), 32'(TSP));
        check("busy_free_time", 32'(f - stop_cyc), 32'(THP));
        check("ready_after_stop", 32'(cmd_ready_o), 32'd1);
        check("lines_released", 32'({scl_o, sda_o}), 32'd3);
      end
      held = !t.stop;
    end
    plan.delete();
  endtask

  function automatic tx_t mk(input bit start, input bit stop, input bit read, input bit nack,
                             input bit ack, input logic [7:0] wdata, input logic [7:0] rdata);
    tx_t t;
    t.start = start; t.stop = stop; t.read = read; t.nack = nack; t.ack = ack;
    t.wdata = wdata; t.rdata = rdata; t.stretch = 1'b0;
    return t;
  endfunction

  initial begin
    tx_t t;
    bit  h, cont;
    repeat (3) @(negedge clk_i);
    check("rst_scl", 32'(scl_o), 32'd1);
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_data", 32'(rsp_data_o), 32'd0);
    check("rst_rsp_nak", 32'(rsp_nak_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;

    // Write 0xA4 with START, ACKed; then write with STOP, NACKed.
    plan.push_back(mk(1, 0, 0, 0, 1, 8'hA4, 8'h00));
    run_plan();
    plan.push_back(mk(0, 1, 0, 0, 0, 8'($urandom()), 8'h00));
    run_plan();
    // Read 0x5A, host NACK, STOP.
    plan.push_back(mk(1, 1, 1, 1, 0, 8'h00, 8'h5A));
    run_plan();
    // Write 0x10 without STOP, then repeated START + read.
    plan.push_back(mk(1, 0, 0, 0, 1, 8'h10, 8'h00));
    plan.push_back(mk(1, 1, 1, 1, 0, 8'h00, 8'($urandom())));
    run_plan();

    // Random legal command stream.
    h = held; cont = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t = mk(0, 0, 0, 0, 1'($urandom()), 8'($urandom()), 8'($urandom()));
      t.read  = cont ? 1'b1 : 1'($urandom());
      t.start = !h ? 1'b1 : (cont ? 1'b0 : (t.read ? 1'b1 : 1'($urandom())));
      t.stop  = (i == 11) ? 1'b1 : ($urandom_range(0, 2) == 0);
      t.nack  = (t.read && t.stop) ? 1'b1 : 1'($urandom());
      cont    = t.read && !t.nack && !t.stop;
      h       = !t.stop;
      plan.push_back(t);
    end
    run_plan();

    // Target stretches SCL during bit 3.
    t = mk(1, 1, 0, 0, 1, 8'($urandom()), 8'h00);
    t.stretch = 1'b1;
    plan.push_back(t);
    run_plan();

    // Reset in the middle of a byte.
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_start_i = 1'b1; cmd_stop_i = 1'b1;
    cmd_read_i = 1'b0; cmd_data_i = 8'hC3;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (20) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_lines", 32'({scl_o, sda_o}), 32'd3);
    check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("midrst_ready", 32'(cmd_ready_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    held = 1'b0;
    plan.push_back(mk(1, 1, 0, 0, 1, 8'h3C, 8'h00));
    run_plan();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/i2c_host_byte_ctrl.md
# i2c_host_byte_ctrl

Synthesizable I2C host (controller) byte engine: it accepts one-byte commands and generates START / repeated START, 8 data bits MSB-first, the ACK/NACK bit and STOP on open-drain SCL/SDA. It is the initiator counterpart of the DV target agent and sits between the I2C host register/FIFO layer and the pad open-drain drivers. All bus timing is in clock cycles, set by parameters.

## Interface
- T_CLOCK_LOW, 4: SCL low-phase cycles per bit (≥1)
- T_CLOCK_HIGH, 4: SCL high-phase cycles per bit (≥1)
- T_SETUP_START, 4: SCL-high cycles before SDA falls on repeated START
- T_HOLD_START, 4: SDA-low cycles with SCL high after START, before SCL falls
- T_SETUP_STOP, 4: SCL-high cycles before SDA rises on STOP
- T_HOLD_STOP, 4: bus-free cycles after STOP
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid && ready
- cmd_start_i  in  1  issue START/repeated START before byte
- cmd_stop_i  in  1  issue STOP after byte
- cmd_read_i  in  1  1: read byte from target; 0: write cmd_data_i
- cmd_nack_i  in  1  read only: host drives NACK (1) instead of ACK
- cmd_data_i  in  8  write byte
- rsp_valid_o  out  1  one-cycle pulse per completed byte
- rsp_data_o  out  8  byte read (write: byte shifted out)
- rsp_nak_o  out  1  ACK-bit sampled SDA value (write: target NACK)
- busy_o  out  1  bus owned (START issued, no STOP completed)
- scl_i, sda_i  in  1  sensed bus lines
- scl_o, sda_o  out  1  0 = drive low, 1 = release

## Operation
- Reset values: scl_o=1, sda_o=1, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_nak_o=0, busy_o=0; state IDLE_FREE. Reset mid-transfer releases both lines in the next cycle with no STOP generated.
- States: IDLE_FREE, IDLE_HELD (scl_o=0, sda_o=1), RS_LOW, RS_SETUP, START_HOLD, BIT_LOW, BIT_HIGH, ACK_LOW, ACK_HIGH, STOP_LOW, STOP_SETUP, STOP_HOLD.
- cmd_ready_o=1 only in IDLE_FREE/IDLE_HELD.
- Accept in IDLE_FREE: sda_o=0 → START_HOLD. cmd_start_i=0 here is illegal; a START is forced anyway.
- Accept in IDLE_HELD with start: RS_LOW (T_CLOCK_LOW, sda_o=1) → RS_SETUP (scl_o=1, T_SETUP_START) → sda_o=0 → START_HOLD. Without start: go directly to BIT_LOW.
- START_HOLD (T_HOLD_START) → scl_o=0 → BIT_LOW, busy_o=1.
- Bits 7..0: BIT_LOW drives sda_o=data bit (read: 1) for T_CLOCK_LOW; BIT_HIGH releases scl for T_CLOCK_HIGH; sda_i is sampled into the shift register in the last high cycle.
- Ack bit: sda_o = write?1:cmd_nack_i; sample sda_i into rsp_nak_o on the last high cycle.
- After ack, with stop: STOP_LOW (scl_o=0, sda_o=0, T_CLOCK_LOW) → STOP_SETUP (scl_o=1, T_SETUP_STOP) → sda_o=1 → STOP_HOLD (T_HOLD_STOP) → IDLE_FREE, busy_o=0. Without stop: IDLE_HELD.

## Timing
- Each phase counter loads at phase entry and runs exactly N cycles.
- rsp_valid_o is registered and high for the one cycle after the final ACK_HIGH cycle. The same cycle enters IDLE_HELD or STOP_LOW. No backpressure.
- Byte time is 9×(T_CLOCK_LOW+T_CLOCK_HIGH) cycles.
- Start from free: START_HOLD occupies cycles a+1..a+T_HOLD_START after accept cycle a.
- A new command may be accepted in the same cycle rsp_valid_o is high when entering IDLE_HELD.
- Counter width: $clog2(max parameter + 1). Parameter value 0 is illegal (elaboration assertion).

## Configuration
- I2C_HOST_CLK_STRETCH_EN defined: high-phase counters (BIT_HIGH, ACK_HIGH, RS_SETUP, STOP_SETUP) hold until scl_i==1, so a target holding SCL low stretches the bit.
- Not defined: scl_i is ignored and all timing is fixed.

## Structure
- i2c_host_pkg: state enum, command struct {start, stop, read, nack, data}, default timing localparams.
- Sub-module i2c_host_phase_cnt: loadable down-counter with a stall input (stretch) and a done pulse.

## Test plan
- Default params, write 0xA4 with start, target ACKs: SDA falls while SCL is high; bits 1,0,1,0,0,1,0,0 appear on SCL rises; rsp_valid_o at a+77 with rsp_nak_o=0, busy_o=1.
- Write with stop, target leaves SDA high: rsp_nak_o=1; STOP rising edge of SDA occurs with SCL high; busy_o=0 after T_HOLD_STOP; cmd_ready_o=1.
- Read, target drives 0x5A, cmd_nack_i=1, stop: rsp_data_o=0x5A; sda_o=1 during ack; STOP follows.
- Write 0x10 without stop, then start+read: repeated START (SDA falls after T_SETUP_START with SCL high), no intervening STOP.
- Stretch enabled, target holds SCL low 20 cycles at bit 3: byte completes 20 cycles late; rsp_data_o is correct.
- rst_i asserted mid-bit: scl_o=sda_o=1 the next cycle, rsp_valid_o=0, cmd_ready_o=1.
